mem_wait_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data/instruction bus. It accepts one word read or write request at a time over a request/acknowledge handshake and inserts a programmable number of wait states. It services the request from an internal word-addressed RAM and returns a single-cycle acknowledge with read data. It sits behind the CPU's IorD-selected address and its B-register write data, standing in for the zero-wait `Memoria` when stalling behaviour must be exercised.

---
 rtl/mem_wait_responder.sv | 127 ++++++++++++
 tb/tb_mem_wait_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_responder.sv
// Wait-state memory responder: one word request at a time, LATENCY wait cycles, single-cycle ack.
// Optional MEM_RESP_ERR_CHECK_EN flags misaligned or out-of-range addresses instead of accessing RAM.
module mem_wait_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic                we_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic [31:0]         mem [2**ADDR_W];

    logic                accept;
    logic                enter_resp;
    logic                req_err;
    logic                acc_we;
    logic                acc_err;
    logic [ADDR_W-1:0]   acc_idx;
    logic [31:0]         acc_wdata;

`ifdef MEM_RESP_ERR_CHECK_EN
    assign req_err = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[1:0], addr[31:ADDR_W+2]};
    assign req_err = 1'b0;
`endif

    assign accept = (state == IDLE) && req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (LATENCY == 0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: if (cnt == 4'd1) begin
                state_nxt  = RESP;
                enter_resp = 1'b1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack  = (state == RESP);
        busy = (state != IDLE);
        err  = (state == RESP) && err_q;
    end

    // With zero latency the access happens on the acceptance edge, so take the live inputs then.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = we;
            acc_err   = req_err;
            acc_idx   = addr[ADDR_W+1:2];
            acc_wdata = wdata;
        end else begin
            acc_we    = we_q;
            acc_err   = err_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            cnt     <= (LATENCY == 0) ? 4'd0 : 4'(LATENCY);
            we_q    <= we;
            idx_q   <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            err_q   <= req_err;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (enter_resp) begin
            if (acc_err)     rdata <= '0;
            else if (!acc_we) rdata <= mem[acc_idx];
        end
    end

    // RAM is not reset; the reset gate only matters for a zero-latency accept during reset.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_err && reset)
            mem[acc_idx] <= acc_wdata;
    end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Bench for mem_wait_responder: two instances (LATENCY=2 and LATENCY=0) checked against a
// transaction-level model; honours MEM_RESP_ERR_CHECK_EN when the design is built with it.
module tb_mem_wait_responder;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        busy  [2];
    logic        err   [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m  [2][2**AW];
    logic [31:0] last_m [2];

    always #5 clk = ~clk;

    mem_wait_responder #(.ADDR_W(AW), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]), .err(err[0]));

    mem_wait_responder #(.ADDR_W(AW), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]), .err(err[1]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_is_bad(input logic [31:0] a);
`ifdef MEM_RESP_ERR_CHECK_EN
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
`else
        return 1'b0;
`endif
    endfunction

    // Transaction-level reference: apply one request, return rdata/err expected at its ack.
    task automatic model_access(input int d, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] exp_rd,
                                output logic exp_err);
        logic [AW-1:0] idx;
        idx     = a[AW+1:2];
        exp_err = addr_is_bad(a);
        if (exp_err)  last_m[d] = '0;
        else if (w)   mem_m[d][idx] = wd;
        else          last_m[d] = mem_m[d][idx];
        exp_rd = last_m[d];
    endtask

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        lat = lat_of(d);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        model_access(d, w, a, wd, exp_rd, exp_err);
        @(negedge clk);
        req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) @(negedge clk);
            check("busy_in_txn", 32'(busy[d]), 32'd1);
            check("ack_timing", 32'(ack[d]), (k == lat) ? 32'd1 : 32'd0);
            if (k == lat) begin
                check("rdata_at_ack", rdata[d], exp_rd);
                check("err_at_ack", 32'(err[d]), 32'(exp_err));
            end
        end
        @(negedge clk);
        check("busy_after", 32'(busy[d]), 32'd0);
        check("ack_after", 32'(ack[d]), 32'd0);
        check("rdata_held", rdata[d], exp_rd);
        check("err_after", 32'(err[d]), 32'd0);
    endtask

    task automatic held_req_test;
        int          n_ack;
        int          first;
        int          prev;
        logic [31:0] exp_rd;
        exp_rd = mem_m[0][4];
        n_ack = 0; first = -1; prev = -1;
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) addr[0] = 32'h20;
            if (c == 3) addr[0] = 32'h10;
            if (c == 10) req[0] = 1'b0;
            if (ack[0]) begin
                n_ack++;
                check("held_rdata", rdata[0], exp_rd);
                check("held_err", 32'(err[0]), 32'(addr_is_bad(32'h10)));
                if (prev >= 0) check("held_spacing", 32'(c - prev), 32'(lat_of(0) + 2));
                else first = c;
                prev = c;
            end
        end
        check("held_ack_count", 32'(n_ack), 32'd3);
        check("held_first_ack", 32'(first), 32'(lat_of(0) + 1));
        last_m[0] = exp_rd;
    endtask

    task automatic reset_mid_txn_test;
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_ack", 32'(ack[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        last_m[0] = '0;
        last_m[1] = '0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
            last_m[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ack", 32'(ack[d]), 32'd0);
            check("reset_busy", 32'(busy[d]), 32'd0);
            check("reset_err", 32'(err[d]), 32'd0);
            check("reset_rdata", rdata[d], 32'd0);
        end
        reset = 1'b1;

        // Preload the words the random phase touches so every read has a known value.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++)
                txn(d, 1'b1, 32'(w * 4), $urandom);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
        txn(0, 1'b0, 32'h10, 32'h0);
        txn(1, 1'b1, 32'h4, 32'h12345678);
        txn(1, 1'b0, 32'h4, 32'h0);
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 32'h8, 32'hAAAA5555);
            txn(d, 1'b0, 32'h8, 32'h0);
            txn(d, 1'b1, 32'hC, 32'h1);
        end

        txn(0, 1'b1, 32'h20, 32'h5A5A0F0F);
        held_req_test();

        txn(0, 1'b1, 32'h20, 32'hCAFEF00D);
        reset_mid_txn_test();
        txn(0, 1'b0, 32'h20, 32'h0);
        txn(1, 1'b1, 32'h30, 32'h13579BDF);

        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 32'h12, 32'hFEEDFACE);
            txn(d, 1'b0, 32'h10, 32'h0);
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                logic [31:0] a;
                a = 32'($urandom_range(0, 15)) << 2;
                if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 7) == 0) a[31:AW+2] = 22'($urandom_range(1, 1023));
                txn(d, 1'($urandom), a, $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
